// File: rtl/multicycle_main_control_pkg.sv
// Shared constants, encodings and types for the multicycle main controller.
package riscv_ctrl_pkg;

    // Opcodes and funct3 values of the supported instruction subset
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LD_SD = 3'b011;
    localparam logic [2:0] F3_BEQ   = 3'b000;

    // ALUOp encodings seen by ALU control
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    // ALU B-operand select encodings
    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_FOUR = 2'b01,
        SRCB_IMM  = 2'b10
    } srcb_e;

    // Controller states
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_LOAD_WB  = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_ILLEGAL  = 4'd9
    } state_e;

    // Bundle of every datapath control output, so it can be cleared in one go
    typedef struct packed {
        logic       memReq;
        logic       memRead;
        logic       memWrite;
        logic       iorD;
        logic       irWrite;
        logic       pcWrite;
        logic       pcWriteCond;
        logic       pcSource;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       regWrite;
        logic       memtoReg;
        logic       illegalInstr;
        logic       busError;
    } ctrl_t;

    // State reached from DECODE for a given opcode/funct3 pair
    function automatic state_e decodeState(input logic [6:0] opcode, input logic [2:0] funct3);
        state_e nextState;
        case (opcode)
            OPC_RTYPE:           nextState = ST_EXEC_R;
            OPC_LOAD, OPC_STORE: nextState = (funct3 == F3_LD_SD) ? ST_MEM_ADDR : ST_ILLEGAL;
            OPC_BRANCH:          nextState = (funct3 == F3_BEQ) ? ST_BRANCH : ST_ILLEGAL;
            default:             nextState = ST_ILLEGAL;
        endcase
        return nextState;
    endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// Instruction-field, memory-handshake and datapath-control bundle of the main controller.
interface multicycle_main_control_if #(
    parameter int CNT_WIDTH = 32
);
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 mem_ready;
    logic                 mem_req;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 IorD;
    logic                 IRWrite;
    logic                 PCWrite;
    logic                 PCWriteCond;
    logic                 PCSource;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ALUOp;
    logic                 RegWrite;
    logic                 MemtoReg;
    logic                 illegal_instr;
    logic                 bus_error;
    logic [CNT_WIDTH-1:0] retired;

    modport master (
        input  opcode, funct3, mem_ready,
        output mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
               PCSource, ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemtoReg,
               illegal_instr, bus_error, retired
    );

    modport slave (
        output opcode, funct3, mem_ready,
        input  mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
               PCSource, ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemtoReg,
               illegal_instr, bus_error, retired
    );
endinterface

// File: rtl/multicycle_main_control_mem_timeout_counter.sv
// Counts unanswered memory-request cycles and flags the final allowed cycle.
module mem_timeout_counter #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);
    localparam int CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear has priority so every new memory access starts from zero
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Wait-cycle counter register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = count_i && (count_q == LAST);

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback for the datapath.
module multicycle_main_control
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    multicycle_main_control_if.master ctrl
);
    state_e               state_q;
    state_e               state_d;
    logic [CNT_WIDTH-1:0] retired_q;
    logic [CNT_WIDTH-1:0] retired_d;
    ctrl_t                ctrlRaw;
    ctrl_t                ctrlOut;
    logic                 retire;
    logic                 memState;
    logic                 waitCycle;
    logic                 expire;

    assign memState  = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
    assign waitCycle = memState && !ctrl.mem_ready;

    mem_timeout_counter #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear_i (!memState || ctrl.mem_ready || expire),
        .count_i (waitCycle),
        .expire_o(expire)
    );

    // Next state, per-state control outputs and retire decision
    always_comb begin
        state_d   = state_q;
        ctrlRaw   = '0;
        retire    = 1'b0;
        retired_d = retired_q;
        case (state_q)
            ST_FETCH: begin
                ctrlRaw.memReq  = 1'b1;
                ctrlRaw.memRead = 1'b1;
                ctrlRaw.aluSrcB = SRCB_FOUR;
                ctrlRaw.aluOp   = ALUOP_ADD;
                if (ctrl.mem_ready) begin
                    ctrlRaw.irWrite = 1'b1;
                    ctrlRaw.pcWrite = 1'b1;
                    state_d         = ST_DECODE;
                end else if (expire) begin
                    ctrlRaw.busError = 1'b1;
                    state_d          = ST_FETCH;
                end
            end
            ST_DECODE: begin
                ctrlRaw.aluSrcB = SRCB_IMM;
                ctrlRaw.aluOp   = ALUOP_ADD;
                state_d         = decodeState(ctrl.opcode, ctrl.funct3);
            end
            ST_MEM_ADDR: begin
                ctrlRaw.aluSrcA = 1'b1;
                ctrlRaw.aluSrcB = SRCB_IMM;
                ctrlRaw.aluOp   = ALUOP_ADD;
                state_d         = (ctrl.opcode == OPC_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                ctrlRaw.memReq  = 1'b1;
                ctrlRaw.memRead = 1'b1;
                ctrlRaw.iorD    = 1'b1;
                if (ctrl.mem_ready) begin
                    state_d = ST_LOAD_WB;
                end else if (expire) begin
                    ctrlRaw.busError = 1'b1;
                    state_d          = ST_FETCH;
                end
            end
            ST_LOAD_WB: begin
                ctrlRaw.regWrite = 1'b1;
                ctrlRaw.memtoReg = 1'b1;
                retire           = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_MEM_WR: begin
                ctrlRaw.memReq   = 1'b1;
                ctrlRaw.memWrite = 1'b1;
                ctrlRaw.iorD     = 1'b1;
                if (ctrl.mem_ready) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (expire) begin
                    ctrlRaw.busError = 1'b1;
                    state_d          = ST_FETCH;
                end
            end
            ST_EXEC_R: begin
                ctrlRaw.aluSrcA = 1'b1;
                ctrlRaw.aluSrcB = SRCB_RS2;
                ctrlRaw.aluOp   = ALUOP_FUNCT;
                state_d         = ST_R_WB;
            end
            ST_R_WB: begin
                ctrlRaw.regWrite = 1'b1;
                retire           = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrlRaw.aluSrcA     = 1'b1;
                ctrlRaw.aluSrcB     = SRCB_RS2;
                ctrlRaw.aluOp       = ALUOP_SUB;
                ctrlRaw.pcWriteCond = 1'b1;
                ctrlRaw.pcSource    = 1'b1;
                retire              = 1'b1;
                state_d             = ST_FETCH;
            end
            ST_ILLEGAL: begin
                ctrlRaw.illegalInstr = 1'b1;
                state_d              = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        if (retire) begin
            retired_d = retired_q + 1'b1;
        end
    end

    // State and retired-instruction registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Every output is held at zero while reset is asserted, even mid-access
    assign ctrlOut = reset_n ? ctrlRaw : '0;

    assign ctrl.mem_req       = ctrlOut.memReq;
    assign ctrl.MemRead       = ctrlOut.memRead;
    assign ctrl.MemWrite      = ctrlOut.memWrite;
    assign ctrl.IorD          = ctrlOut.iorD;
    assign ctrl.IRWrite       = ctrlOut.irWrite;
    assign ctrl.PCWrite       = ctrlOut.pcWrite;
    assign ctrl.PCWriteCond   = ctrlOut.pcWriteCond;
    assign ctrl.PCSource      = ctrlOut.pcSource;
    assign ctrl.ALUSrcA       = ctrlOut.aluSrcA;
    assign ctrl.ALUSrcB       = ctrlOut.aluSrcB;
    assign ctrl.ALUOp         = ctrlOut.aluOp;
    assign ctrl.RegWrite      = ctrlOut.regWrite;
    assign ctrl.MemtoReg      = ctrlOut.memtoReg;
    assign ctrl.illegal_instr = ctrlOut.illegalInstr;
    assign ctrl.bus_error     = ctrlOut.busError;
    assign ctrl.retired       = reset_n ? retired_q : '0;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for the multicycle main controller with a short memory timeout.
module tb_multicycle_main_control;

    logic clock = 1'b0;
    logic reset_n;
    int   compareCount  = 0;
    int   mismatchCount = 0;

    multicycle_main_control_if #(.CNT_WIDTH(32)) bus ();

    multicycle_main_control #(
        .MEM_TIMEOUT(4),
        .CNT_WIDTH  (32)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .ctrl   (bus.master)
    );

    always #5 clock = ~clock;

    // Control vector layout, msb first:
    // mem_req MemRead MemWrite IorD | IRWrite PCWrite PCWriteCond PCSource |
    // ALUSrcA | ALUSrcB[1:0] | ALUOp[1:0] | RegWrite MemtoReg illegal_instr bus_error
    localparam logic [16:0] V_ZERO   = 17'b0000_0000_0_00_00_0000;
    localparam logic [16:0] V_F_WAIT = 17'b1100_0000_0_01_00_0000;
    localparam logic [16:0] V_F_RDY  = 17'b1100_1100_0_01_00_0000;
    localparam logic [16:0] V_F_TO   = 17'b1100_0000_0_01_00_0001;
    localparam logic [16:0] V_DEC    = 17'b0000_0000_0_10_00_0000;
    localparam logic [16:0] V_MADDR  = 17'b0000_0000_1_10_00_0000;
    localparam logic [16:0] V_MRD    = 17'b1101_0000_0_00_00_0000;
    localparam logic [16:0] V_LWB    = 17'b0000_0000_0_00_00_1100;
    localparam logic [16:0] V_MWR    = 17'b1011_0000_0_00_00_0000;
    localparam logic [16:0] V_EXR    = 17'b0000_0000_1_00_10_0000;
    localparam logic [16:0] V_RWB    = 17'b0000_0000_0_00_00_1000;
    localparam logic [16:0] V_BR     = 17'b0000_0011_1_00_01_0000;
    localparam logic [16:0] V_ILL    = 17'b0000_0000_0_00_00_0010;

    function automatic logic [31:0] ctrlVec();
        return {15'b0, bus.mem_req, bus.MemRead, bus.MemWrite, bus.IorD,
                bus.IRWrite, bus.PCWrite, bus.PCWriteCond, bus.PCSource,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.RegWrite, bus.MemtoReg, bus.illegal_instr, bus.bus_error};
    endfunction

    // Drive reset and mem_ready on the falling edge, then let outputs settle
    task automatic applyStimulus(input logic rstN, input logic ready);
        @(negedge clock);
        reset_n       = rstN;
        bus.mem_ready = ready;
        #1;
    endtask

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic runCycle(input string tag, input logic rstN, input logic ready, input logic [16:0] expVec);
        applyStimulus(rstN, ready);
        checkOutput(tag, ctrlVec(), {15'b0, expVec});
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.opcode    = 7'b0;
        bus.funct3    = 3'b0;
        bus.mem_ready = 1'b0;

        $display("[TB] reset");
        runCycle("rst_ctrl", 1'b0, 1'b0, V_ZERO);
        checkOutput("rst_retired", bus.retired, 32'd0);
        runCycle("rst_ctrl2", 1'b0, 1'b0, V_ZERO);

        $display("[TB] R-type");
        bus.opcode = 7'b0110011;
        bus.funct3 = 3'b000;
        runCycle("r_fetch", 1'b1, 1'b1, V_F_RDY);
        checkOutput("r_ret_before", bus.retired, 32'd0);
        runCycle("r_decode", 1'b1, 1'b1, V_DEC);
        runCycle("r_exec", 1'b1, 1'b1, V_EXR);
        runCycle("r_wb", 1'b1, 1'b1, V_RWB);
        checkOutput("r_ret_in_wb", bus.retired, 32'd0);

        $display("[TB] ld with three wait cycles");
        bus.opcode = 7'b0000011;
        bus.funct3 = 3'b011;
        runCycle("ld_fetch", 1'b1, 1'b1, V_F_RDY);
        checkOutput("ld_ret_after_r", bus.retired, 32'd1);
        runCycle("ld_decode", 1'b1, 1'b1, V_DEC);
        runCycle("ld_addr", 1'b1, 1'b1, V_MADDR);
        for (int i = 0; i < 3; i++) begin
            runCycle("ld_memrd_wait", 1'b1, 1'b0, V_MRD);
        end
        runCycle("ld_memrd_done", 1'b1, 1'b1, V_MRD);
        runCycle("ld_wb", 1'b1, 1'b1, V_LWB);

        $display("[TB] beq");
        bus.opcode = 7'b1100011;
        bus.funct3 = 3'b000;
        runCycle("beq_fetch", 1'b1, 1'b1, V_F_RDY);
        checkOutput("beq_ret_after_ld", bus.retired, 32'd2);
        runCycle("beq_decode", 1'b1, 1'b1, V_DEC);
        runCycle("beq_branch", 1'b1, 1'b1, V_BR);

        $display("[TB] illegal opcode and illegal funct3");
        bus.opcode = 7'b0010011;
        bus.funct3 = 3'b000;
        runCycle("ill_fetch", 1'b1, 1'b1, V_F_RDY);
        checkOutput("ill_ret_after_beq", bus.retired, 32'd3);
        runCycle("ill_decode", 1'b1, 1'b1, V_DEC);
        runCycle("ill_pulse", 1'b1, 1'b1, V_ILL);
        bus.opcode = 7'b0000011;
        bus.funct3 = 3'b010;
        runCycle("ill_f3_fetch", 1'b1, 1'b1, V_F_RDY);
        checkOutput("ill_ret_hold", bus.retired, 32'd3);
        runCycle("ill_f3_decode", 1'b1, 1'b1, V_DEC);
        runCycle("ill_f3_pulse", 1'b1, 1'b1, V_ILL);

        $display("[TB] sd zero wait");
        bus.opcode = 7'b0100011;
        bus.funct3 = 3'b011;
        runCycle("sd_fetch", 1'b1, 1'b1, V_F_RDY);
        checkOutput("sd_ret_after_ill", bus.retired, 32'd3);
        runCycle("sd_decode", 1'b1, 1'b1, V_DEC);
        runCycle("sd_addr", 1'b1, 1'b1, V_MADDR);
        runCycle("sd_memwr", 1'b1, 1'b1, V_MWR);

        $display("[TB] fetch timeout");
        for (int i = 0; i < 3; i++) begin
            runCycle("to_wait", 1'b1, 1'b0, V_F_WAIT);
        end
        checkOutput("to_ret_after_sd", bus.retired, 32'd4);
        runCycle("to_expire", 1'b1, 1'b0, V_F_TO);
        runCycle("to_refetch", 1'b1, 1'b0, V_F_WAIT);
        runCycle("to_wait2", 1'b1, 1'b0, V_F_WAIT);
        runCycle("to_wait3", 1'b1, 1'b0, V_F_WAIT);
        runCycle("to_ready_wins", 1'b1, 1'b1, V_F_RDY);
        checkOutput("to_ret_hold", bus.retired, 32'd4);

        $display("[TB] reset during sd wait");
        runCycle("sd2_decode", 1'b1, 1'b1, V_DEC);
        runCycle("sd2_addr", 1'b1, 1'b1, V_MADDR);
        runCycle("sd2_memwr_wait", 1'b1, 1'b0, V_MWR);
        runCycle("rst_mid", 1'b0, 1'b0, V_ZERO);
        checkOutput("rst_mid_retired", bus.retired, 32'd0);
        runCycle("rst_hold", 1'b0, 1'b0, V_ZERO);
        runCycle("rst_release", 1'b1, 1'b0, V_F_WAIT);
        checkOutput("rst_release_retired", bus.retired, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
